// File: rtl/adsr_pkg.sv
// Shared state encoding and scalar limits for the ADSR envelope sequencer.
package adsr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } adsr_state_e;

    // Silence shift: large enough to drive a 20-bit sample to zero.
    localparam logic [4:0] SMAX      = 5'd21;
    localparam logic [4:0] SUS_LIMIT = 5'd20;

endpackage

// File: rtl/adsr_shift_scaler.sv
// Registered attenuator: out = in >> scalar, one cycle of latency.
module adsr_shift_scaler #(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in,
    input  logic [4:0]   scalar,
    output logic [W-1:0] out
);

    logic [W-1:0] out_q;

    // Logical shift by scalar >= W naturally yields zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else begin
            out_q <= in >> scalar;
        end
    end

    assign out = out_q;

endmodule

// File: rtl/adsr_sequencer.sv
// ADSR envelope sequencer: gate-driven FSM stepping a shift scalar once per tick.
module adsr_sequencer #(
    parameter int W    = 20,
    parameter int SMAX = adsr_pkg::SMAX
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         tick,
    input  logic         gate,
    input  logic [4:0]   sustain_level,
    input  logic [W-1:0] in,
    output logic [W-1:0] out,
    output logic [4:0]   scalar,
    output logic [2:0]   stage,
    output logic         end_release
);
    import adsr_pkg::*;

    localparam logic [4:0] SMAX_V = 5'(SMAX);

    adsr_state_e state_q, state_d;
    logic [4:0]  scalar_q, scalar_d;
    logic        gate_q;
    logic        end_rel_q, end_rel_d;
    logic        rise, fall, idle_s;
    logic [4:0]  sus_s;

    function automatic logic [4:0] sat_inc(input logic [4:0] v, input logic [4:0] lim);
        return (v >= lim) ? lim : v + 5'd1;
    endfunction

    function automatic logic [4:0] sat_dec(input logic [4:0] v);
        return (v == 5'd0) ? 5'd0 : v - 5'd1;
    endfunction

    assign rise   = gate & ~gate_q;
    assign fall   = ~gate & gate_q;
    assign idle_s = (state_q == ST_IDLE) || (state_q > ST_RELEASE);
    assign sus_s  = (sustain_level > SUS_LIMIT) ? SUS_LIMIT : sustain_level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            scalar_q  <= SMAX_V;
            gate_q    <= 1'b0;
            end_rel_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            scalar_q  <= scalar_d;
            gate_q    <= gate;
            end_rel_q <= end_rel_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        scalar_d  = scalar_q;
        end_rel_d = 1'b0;
        if (idle_s) begin
            state_d  = ST_IDLE;
            scalar_d = SMAX_V;
        end
        // Any gate edge wins over a coincident tick; the tick is simply lost.
        if (rise) begin
            state_d = ST_ATTACK;
        end else if (fall) begin
            if (state_q == ST_ATTACK || state_q == ST_DECAY || state_q == ST_SUSTAIN) begin
                state_d = ST_RELEASE;
            end
        end else if (tick) begin
            case (state_q)
                ST_ATTACK: begin
                    scalar_d = sat_dec(scalar_q);
                    if (scalar_d == 5'd0) state_d = ST_DECAY;
                end
                ST_DECAY: begin
                    if (scalar_q < sus_s) begin
                        scalar_d = sat_inc(scalar_q, sus_s);
                        if (scalar_d == sus_s) state_d = ST_SUSTAIN;
                    end else begin
                        state_d = ST_SUSTAIN;
                    end
                end
                ST_SUSTAIN: begin
                    if (scalar_q < sus_s) begin
                        scalar_d = sat_inc(scalar_q, sus_s);
                    end else if (scalar_q > sus_s) begin
                        scalar_d = sat_dec(scalar_q);
                    end
                end
                ST_RELEASE: begin
                    scalar_d = sat_inc(scalar_q, SMAX_V);
                    if (scalar_d == SMAX_V) begin
                        state_d   = ST_IDLE;
                        end_rel_d = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    adsr_shift_scaler #(.W(W)) u_scaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .in     (in),
        .scalar (scalar_q),
        .out    (out)
    );

    assign scalar      = scalar_q;
    assign stage       = idle_s ? ST_IDLE : state_q;
    assign end_release = end_rel_q;

endmodule
